// File: rtl/sram_rd_pkg.sv
// Shared widths and FSM encoding for the SRAM burst read master.
package sram_rd_pkg;

    localparam int ADDR_W    = 11;
    localparam int DATA_W    = 32;
    localparam int LEN_W     = 12;
    localparam int BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } rd_state_e;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry register FIFO; entry 0 is always the head and feeds the output directly.
module skid_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic [1:0]   count_q, count_d;
    logic         pop_ok, push_ok, wr_hi;

    always_comb begin
        pop_ok  = pop && (count_q != 2'd0);
        push_ok = push && ((count_q != 2'd2) || pop_ok);
        // Write slot is the first free entry after this cycle's pop shifts the queue.
        wr_hi   = (count_q == 2'd2) || ((count_q == 2'd1) && !pop_ok);
        mem_d   = mem_q;
        if (pop_ok) begin
            mem_d[0] = mem_q[1];
        end
        if (push_ok) begin
            if (wr_hi) begin
                mem_d[1] = din;
            end else begin
                mem_d[0] = din;
            end
        end
        count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[0];

endmodule

// File: rtl/sram_burst_reader.sv
// Burst read master for the 32b x 2048 activation SRAM, streaming words over valid/ready.
// Optional running checksum port enabled by SRAM_BURST_READER_CHECKSUM_EN.
module sram_burst_reader
    import sram_rd_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              CEN,
    output logic              WEN,
    output logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] Q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef SRAM_BURST_READER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    rd_state_e         state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [ADDR_W-1:0] nxt_addr_q, nxt_addr_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic              inflight_q, inflight_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [1:0]        buf_count;
    logic              pop, issue, drained;
    logic [2:0]        occ;

    // Occupancy counts the buffered word leaving this cycle as free, so a full
    // pipeline keeps issuing one read per cycle while downstream keeps accepting.
    always_comb begin
        out_valid = (buf_count != 2'd0);
        pop       = out_valid && out_ready;
        occ       = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = (state_q == READ) && (issued_q != len_q) && (occ < 3'd2);
        drained   = !inflight_q && ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop));
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q;
        nxt_addr_d = nxt_addr_q;
        a_d        = a_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        inflight_d = issue;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d      = length;
                    issued_d   = '0;
                    nxt_addr_d = base_addr;
                    if (length == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = READ;
                        busy_d  = 1'b1;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    issued_d   = issued_q + 1'b1;
                    nxt_addr_d = nxt_addr_q + 1'b1;
                    a_d        = nxt_addr_q;
                    if (issued_d == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            nxt_addr_q <= '0;
            a_q        <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            nxt_addr_q <= nxt_addr_d;
            a_q        <= a_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // A holds the last issued address between issues; reset forces CEN high at once.
    assign CEN  = !issue;
    assign WEN  = 1'b1;
    assign A    = issue ? nxt_addr_q : a_q;
    assign busy = busy_q;
    assign done = done_q;

    skid_fifo2 #(
        .W(DATA_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESET_N),
        .push  (inflight_q),
        .pop   (pop),
        .din   (Q),
        .count (buf_count),
        .head  (out_data)
    );

`ifdef SRAM_BURST_READER_CHECKSUM_EN
    logic [DATA_W-1:0] cksum_q, cksum_d;

    always_comb begin
        cksum_d = cksum_q;
        if ((state_q == IDLE) && start) begin
            cksum_d = '0;
        end else if (pop) begin
            cksum_d = cksum_q + out_data;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cksum_q <= '0;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign checksum = cksum_q;
`endif

endmodule
